// File: rtl/toggle_set_scheduler_pkg.sv
// Shared types and defaults for the toggle memory set scheduler.
// The state enum, the request struct and a pointer-width helper live here.
package toggle_set_scheduler_pkg;

   localparam int unsigned TSS_DEPTH           = 64;
   localparam int unsigned TSS_NUM_REQ         = 4;
   localparam int unsigned TSS_NUM_WRITE_PORTS = 2;
   localparam int unsigned TSS_INIT_CYCLES     = 64;
   localparam int unsigned TSS_ADDR_W          = $clog2(TSS_DEPTH);

   typedef enum logic [1:0] {
      StStart,
      StClear,
      StRun
   } tss_state_e;

   typedef struct packed {
      logic                  valid;
      logic [TSS_ADDR_W-1:0] addr;
   } toggle_req_t;

   // Index width that stays at least one bit wide for single-entry ranges.
   function automatic int unsigned idx_width(int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/toggle_set_scheduler_if.sv
// Requester / toggle-set side signals of the scheduler, grouped as one bundle.
// master = requesters plus the set model; slave = the scheduler itself.
interface toggle_set_scheduler_if
   import toggle_set_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ         = TSS_NUM_REQ,
   parameter int unsigned NUM_WRITE_PORTS = TSS_NUM_WRITE_PORTS,
   parameter int unsigned AW              = TSS_ADDR_W
);
   logic                                restart_init;
   logic [NUM_REQ-1:0]                  req_valid;
   logic [NUM_REQ-1:0][AW-1:0]          req_addr;
   logic [NUM_REQ-1:0]                  req_ready;
   logic [NUM_WRITE_PORTS-1:0]          toggle;
   logic [NUM_WRITE_PORTS-1:0][AW-1:0]  toggle_addr;
   logic                                init_clear;
   logic                                init_done;

   modport master (
      output restart_init, req_valid, req_addr,
      input  req_ready, toggle, toggle_addr, init_clear, init_done
   );

   modport slave (
      input  restart_init, req_valid, req_addr,
      output req_ready, toggle, toggle_addr, init_clear, init_done
   );
endinterface

// File: rtl/toggle_set_scheduler_rr_multi_grant.sv
// Combinational round-robin picking up to NUM_WRITE_PORTS of NUM_REQ requesters.
// Port p gets the p-th valid requester in scan order starting at the pointer.
module toggle_set_scheduler_rr_multi_grant
   import toggle_set_scheduler_pkg::*;
#(
   parameter int unsigned NUM_REQ         = TSS_NUM_REQ,
   parameter int unsigned NUM_WRITE_PORTS = TSS_NUM_WRITE_PORTS,
   parameter int unsigned PW              = idx_width(NUM_REQ)
) (
   input  logic                                     i_enable,
   input  logic [NUM_REQ-1:0]                       i_valid,
   input  logic [PW-1:0]                            i_ptr,
   output logic [NUM_WRITE_PORTS-1:0][NUM_REQ-1:0]  o_sel,
   output logic [NUM_REQ-1:0]                       o_grant,
   output logic [PW-1:0]                            o_next_ptr
);
   localparam int unsigned SW = idx_width(NUM_WRITE_PORTS);
   localparam int unsigned GW = $clog2(NUM_WRITE_PORTS + 1);

   logic [PW-1:0] w_idx;
   logic [GW-1:0] w_cnt;

   always_comb begin
      o_sel      = '0;
      o_grant    = '0;
      o_next_ptr = i_ptr;
      w_idx      = '0;
      w_cnt      = '0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         w_idx = PW'((32'(i_ptr) + k) % NUM_REQ);
         if (i_enable && i_valid[w_idx] && (32'(w_cnt) < NUM_WRITE_PORTS)) begin
            o_sel[w_cnt[SW-1:0]][w_idx] = 1'b1;
            o_grant[w_idx]              = 1'b1;
            o_next_ptr                  = PW'((32'(w_idx) + 1) % NUM_REQ);
            w_cnt                       = w_cnt + GW'(1);
         end
      end
   end

endmodule

// File: rtl/toggle_set_scheduler.sv
// Post-reset clear sweep of the in-use toggle set, then round-robin sharing of
// its toggle ports among the requesters with registered toggle strobes.
module toggle_set_scheduler
   import toggle_set_scheduler_pkg::*;
#(
   parameter int unsigned DEPTH           = TSS_DEPTH,
   parameter int unsigned NUM_REQ         = TSS_NUM_REQ,
   parameter int unsigned NUM_WRITE_PORTS = TSS_NUM_WRITE_PORTS,
   parameter int unsigned INIT_CYCLES     = TSS_INIT_CYCLES
) (
   input  logic                    clk,
   input  logic                    rst_n,
   toggle_set_scheduler_if.slave   io_bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = idx_width(NUM_REQ);
   localparam int unsigned CW = idx_width(INIT_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(INIT_CYCLES - 1);

   tss_state_e                                r_state, w_state_d;
   logic [CW-1:0]                             r_cnt, w_cnt_d;
   logic [PW-1:0]                             r_ptr, w_ptr_d, w_rr_next;
   logic                                      r_init_clear, w_init_clear_d;
   logic                                      r_init_done, w_init_done_d;
   toggle_req_t [NUM_WRITE_PORTS-1:0]         r_tgl, w_tgl_d;
   logic                                      w_arb_en;
   logic [NUM_REQ-1:0]                        w_grant;
   logic [NUM_WRITE_PORTS-1:0][NUM_REQ-1:0]   w_sel;

   // A restart cycle grants nothing, so no requester can be lost across the sweep.
   assign w_arb_en = (r_state == StRun) && !io_bus.restart_init;

   toggle_set_scheduler_rr_multi_grant #(
      .NUM_REQ         (NUM_REQ),
      .NUM_WRITE_PORTS (NUM_WRITE_PORTS),
      .PW              (PW)
   ) u_rr (
      .i_enable   (w_arb_en),
      .i_valid    (io_bus.req_valid),
      .i_ptr      (r_ptr),
      .o_sel      (w_sel),
      .o_grant    (w_grant),
      .o_next_ptr (w_rr_next)
   );

   assign io_bus.req_ready  = w_grant;
   assign io_bus.init_clear = r_init_clear;
   assign io_bus.init_done  = r_init_done;

   always_comb begin
      w_tgl_d = '0;
      for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
         w_tgl_d[p].valid = |w_sel[p];
         for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_sel[p][i]) w_tgl_d[p].addr = TSS_ADDR_W'(io_bus.req_addr[i]);
         end
      end
   end

   always_comb begin
      io_bus.toggle      = '0;
      io_bus.toggle_addr = '0;
      for (int unsigned p = 0; p < NUM_WRITE_PORTS; p++) begin
         io_bus.toggle[p]      = r_tgl[p].valid;
         io_bus.toggle_addr[p] = AW'(r_tgl[p].addr);
      end
   end

   always_comb begin
      w_state_d      = r_state;
      w_cnt_d        = r_cnt;
      w_ptr_d        = r_ptr;
      w_init_clear_d = r_init_clear;
      w_init_done_d  = r_init_done;
      unique case (r_state)
         StStart: begin
            w_init_clear_d = 1'b1;
            w_cnt_d        = '0;
            w_state_d      = StClear;
         end
         StClear: begin
            if (r_cnt == CNT_LAST) begin
               w_init_clear_d = 1'b0;
               w_init_done_d  = 1'b1;
               w_cnt_d        = '0;
               w_state_d      = StRun;
            end else begin
               w_cnt_d = r_cnt + CW'(1);
            end
         end
         StRun: begin
            if (io_bus.restart_init) begin
               w_init_done_d = 1'b0;
               w_cnt_d       = '0;
               w_state_d     = StStart;
            end else if (|w_grant) begin
               w_ptr_d = w_rr_next;
            end
         end
         default: w_state_d = StStart;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state      <= StStart;
         r_cnt        <= '0;
         r_ptr        <= '0;
         r_init_clear <= 1'b0;
         r_init_done  <= 1'b0;
         r_tgl        <= '0;
      end else begin
         r_state      <= w_state_d;
         r_cnt        <= w_cnt_d;
         r_ptr        <= w_ptr_d;
         r_init_clear <= w_init_clear_d;
         r_init_done  <= w_init_done_d;
         r_tgl        <= w_tgl_d;
      end
   end

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_hold
      a_hold: assert property (@(posedge clk) disable iff (!rst_n)
         io_bus.req_valid[gi] && !io_bus.req_ready[gi]
         |=> io_bus.req_valid[gi] && $stable(io_bus.req_addr[gi]));
   end

endmodule

// File: tb/tb_toggle_set_scheduler.sv
// Bench for toggle_set_scheduler: directed vector table, hand-written sweep,
// restart and reset sequences, then random traffic against a reference model.
module tb_toggle_set_scheduler;
   import toggle_set_scheduler_pkg::*;

   localparam int NR   = TSS_NUM_REQ;
   localparam int NWP  = TSS_NUM_WRITE_PORTS;
   localparam int INIT = TSS_INIT_CYCLES;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   nchk = 0;
   int   nfail = 0;

   toggle_set_scheduler_if bus ();

   toggle_set_scheduler dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .io_bus (bus)
   );

   always #5 clk = ~clk;

   // Reference model state (abstract phases, not the RTL encoding).
   int         m_mode;   // 0 = start, 1 = clearing, 2 = running
   int         m_left;
   int         m_ptr;
   int         m_gidx[$];
   logic [3:0] m_ready;
   logic [1:0] m_toggle;
   logic [5:0] m_taddr[2];
   logic       m_clear;
   logic       m_done;
   int         wcnt[NR];
   bit         in_use[64];

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_mode = 0; m_left = 0; m_ptr = 0; m_ready = '0; m_toggle = '0;
      m_taddr[0] = '0; m_taddr[1] = '0; m_clear = 1'b0; m_done = 1'b0;
      m_gidx.delete();
      for (int i = 0; i < NR; i++) wcnt[i] = 0;
   endfunction

   // Grants: valid requesters ordered by distance from the pointer, first NWP win.
   function automatic void model_pre(logic restart, logic [3:0] v);
      m_gidx.delete();
      m_ready = '0;
      if (m_mode == 2 && !restart) begin
         for (int d = 0; d < NR; d++) begin
            if (v[(m_ptr + d) % NR] && m_gidx.size() < NWP) m_gidx.push_back((m_ptr + d) % NR);
         end
      end
      foreach (m_gidx[j]) m_ready[m_gidx[j]] = 1'b1;
   endfunction

   function automatic void model_edge(logic restart, logic [3:0][5:0] a);
      m_toggle = '0;
      m_taddr[0] = '0; m_taddr[1] = '0;
      foreach (m_gidx[j]) begin
         m_toggle[j] = 1'b1;
         m_taddr[j]  = a[m_gidx[j]];
      end
      case (m_mode)
         0: begin m_mode = 1; m_left = INIT; m_clear = 1'b1; end
         1: begin
            m_left--;
            if (m_left == 0) begin m_clear = 1'b0; m_done = 1'b1; m_mode = 2; end
         end
         default: begin
            if (restart) begin m_done = 1'b0; m_mode = 0; end
            else if (m_gidx.size() > 0) m_ptr = (m_gidx[m_gidx.size() - 1] + 1) % NR;
         end
      endcase
   endfunction

   // One clock: check ready, take the edge, check registered outputs, drop granted valids.
   task automatic step(output logic [3:0] granted);
      logic [3:0]      rdy;
      logic [3:0][5:0] a;
      logic            rs;
      #1;
      rs = bus.restart_init;
      a  = bus.req_addr;
      model_pre(rs, bus.req_valid);
      rdy = bus.req_ready;
      chk("req_ready", 32'(rdy), 32'(m_ready));
      if (m_mode == 2 && rs) begin
         for (int i = 0; i < NR; i++) wcnt[i] = 0;
      end else if (m_mode == 2) begin
         for (int i = 0; i < NR; i++) begin
            if (bus.req_valid[i] && rdy[i]) begin
               chk("starvation_bound", 32'(wcnt[i] < 2), 32'd1);
               wcnt[i] = 0;
            end else if (bus.req_valid[i]) begin
               wcnt[i]++;
            end
         end
      end
      @(posedge clk);
      model_edge(rs, a);
      #1;
      chk("toggle", 32'(bus.toggle), 32'(m_toggle));
      for (int p = 0; p < NWP; p++) begin
         if (m_toggle[p]) chk("toggle_addr", 32'(bus.toggle_addr[p]), 32'(m_taddr[p]));
      end
      chk("init_clear", 32'(bus.init_clear), 32'(m_clear));
      chk("init_done", 32'(bus.init_done), 32'(m_done));
      if (bus.init_clear) begin
         for (int e = 0; e < 64; e++) in_use[e] = 1'b0;
      end
      for (int p = 0; p < NWP; p++) begin
         if (bus.toggle[p]) in_use[bus.toggle_addr[p]] = ~in_use[bus.toggle_addr[p]];
      end
      bus.req_valid = bus.req_valid & ~rdy;
      granted = rdy;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_toggle", 32'(bus.toggle), 32'd0);
      chk("rst_toggle_addr", 32'(bus.toggle_addr), 32'd0);
      chk("rst_init_clear", 32'(bus.init_clear), 32'd0);
      chk("rst_init_done", 32'(bus.init_done), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_sweep(output int nclear, output logic saw_ready, output logic done_ok);
      logic [3:0] g;
      logic       prev;
      nclear = 0; saw_ready = 1'b0; done_ok = 1'b0;
      for (int c = 0; c < 200; c++) begin
         prev = bus.init_clear;
         step(g);
         saw_ready = saw_ready | (|g);
         if (bus.init_clear) nclear++;
         if (bus.init_done) begin
            done_ok = prev && !bus.init_clear;
            break;
         end
      end
   endtask

   typedef struct {
      logic [3:0]      valid;
      logic [3:0][5:0] addr;
      logic [3:0]      exp_ready;
      logic [1:0]      exp_toggle;
      logic [5:0]      exp_a0;
      logic [5:0]      exp_a1;
   } vec_t;

   vec_t vecs[9];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected finish before %0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      int         nclear;
      logic       saw, dok;
      logic [3:0] g;

      vecs[0] = '{4'b1111, {6'd8, 6'd7, 6'd6, 6'd5},   4'b0011, 2'b11, 6'd5,  6'd6};
      vecs[1] = '{4'b1100, {6'd8, 6'd7, 6'd6, 6'd5},   4'b1100, 2'b11, 6'd7,  6'd8};
      vecs[2] = '{4'b1000, {6'd63, 6'd0, 6'd0, 6'd0},  4'b1000, 2'b01, 6'd63, 6'd0};
      vecs[3] = '{4'b0101, {6'd0, 6'd12, 6'd0, 6'd12}, 4'b0101, 2'b11, 6'd12, 6'd12};
      vecs[4] = '{4'b0000, {6'd0, 6'd0, 6'd0, 6'd0},   4'b0000, 2'b00, 6'd0,  6'd0};
      vecs[5] = '{4'b0011, {6'd0, 6'd0, 6'd2, 6'd1},   4'b0011, 2'b11, 6'd1,  6'd2};
      vecs[6] = '{4'b1111, {6'd30, 6'd20, 6'd11, 6'd10}, 4'b1100, 2'b11, 6'd20, 6'd30};
      vecs[7] = '{4'b0011, {6'd30, 6'd20, 6'd11, 6'd10}, 4'b0011, 2'b11, 6'd10, 6'd11};
      vecs[8] = '{4'b0010, {6'd0, 6'd0, 6'd9, 6'd0},   4'b0010, 2'b01, 6'd9,  6'd0};

      bus.restart_init = 1'b0;
      bus.req_valid    = 4'b1111;
      bus.req_addr     = {6'd8, 6'd7, 6'd6, 6'd5};

      // Sweep after reset with every requester waiting.
      do_reset();
      run_sweep(nclear, saw, dok);
      chk("sweep_len", 32'(nclear), 32'd64);
      chk("sweep_ready_quiet", 32'(saw), 32'd0);
      chk("done_on_clear_fall", 32'(dok), 32'd1);

      // Directed vector table, pointer starts at 0.
      for (int r = 0; r < 9; r++) begin
         bus.req_valid = vecs[r].valid;
         bus.req_addr  = vecs[r].addr;
         step(g);
         chk("vec_ready", 32'(g), 32'(vecs[r].exp_ready));
         chk("vec_toggle", 32'(bus.toggle), 32'(vecs[r].exp_toggle));
         if (vecs[r].exp_toggle[0]) chk("vec_addr0", 32'(bus.toggle_addr[0]), 32'(vecs[r].exp_a0));
         if (vecs[r].exp_toggle[1]) chk("vec_addr1", 32'(bus.toggle_addr[1]), 32'(vecs[r].exp_a1));
         if (r == 3) chk("same_addr_in_use", 32'(in_use[12]), 32'd0);
      end

      // Restart with req1 pending: no grant now, granted right after the new sweep.
      bus.req_valid    = 4'b0010;
      bus.req_addr     = {6'd0, 6'd0, 6'd33, 6'd0};
      bus.restart_init = 1'b1;
      step(g);
      chk("restart_ready", 32'(g), 32'd0);
      bus.restart_init = 1'b0;
      run_sweep(nclear, saw, dok);
      chk("restart_sweep_len", 32'(nclear), 32'd64);
      chk("restart_sweep_quiet", 32'(saw), 32'd0);
      step(g);
      chk("restart_grant", 32'(g), 32'b0010);
      chk("restart_toggle_addr", 32'(bus.toggle_addr[0]), 32'd33);

      // Reset on sweep cycle 30, then a full sweep again.
      bus.req_valid = 4'b0101;
      bus.req_addr  = {6'd4, 6'd3, 6'd2, 6'd1};
      do_reset();
      for (int c = 0; c < 31; c++) step(g);
      chk("mid_sweep_clear", 32'(bus.init_clear), 32'd1);
      do_reset();
      run_sweep(nclear, saw, dok);
      chk("rerun_sweep_len", 32'(nclear), 32'd64);
      chk("rerun_done", 32'(dok), 32'd1);

      // Random traffic with occasional restarts.
      for (int c = 0; c < 500; c++) begin
         for (int i = 0; i < NR; i++) begin
            if (!bus.req_valid[i] && $urandom_range(0, 1) == 1) begin
               bus.req_valid[i] = 1'b1;
               bus.req_addr[i]  = 6'($urandom_range(0, 63));
            end
         end
         bus.restart_init = ($urandom_range(0, 59) == 0);
         step(g);
      end
      bus.restart_init = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end

endmodule
